// File: rtl/pulse_counter_pkg.sv
// Shared types and constants for the pulse counter / seven-segment display block.
// Latency: n/a (package). Backpressure: n/a.
package pulse_counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for BCD 0..9
    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes or blank give all-off.
// Latency: combinational. Backpressure: none.
module seg7_decoder
    import pulse_counter_pkg::*;
(
    input  bcd_digit_t  i_digit,
    input  logic        i_blank,
    output logic [6:0]  o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        for (int k = 0; k < 10; k++) begin
            if (i_digit == bcd_digit_t'(k)) o_seg = SEG_DIGITS[k];
        end
        if (i_blank) o_seg = SEG_BLANK;
    end

endmodule

// File: rtl/pulse_counter_display.sv
// Debounced pulse counter (BCD) driving a multiplexed common-anode display; LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: clean input rise -> count_bcd after DEBOUNCE_CYCLES+3 edges; display outputs registered.
// Backpressure: none; input pulses are free-running and every debounced rise is counted unless cleared.
module pulse_counter_display
    import pulse_counter_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REFRESH_DIV     = 1024
)
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pulse_in,
    input  logic                  clear,
    input  logic                  hold,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  overflow
);

    localparam int DB_W  = clog2(DEBOUNCE_CYCLES + 1);
    localparam int SC_W  = clog2(REFRESH_DIV);
    localparam int SEL_W = (DIGITS > 1) ? clog2(DIGITS) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(REFRESH_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

    logic                 r_sync1, r_sync2;
    logic [DB_W-1:0]      r_db_cnt;
    logic                 r_db_level, r_db_prev;
    logic [4*DIGITS-1:0]  r_count, r_latch;
    logic                 r_overflow;
    logic [SC_W-1:0]      r_scan_cnt;
    logic [SEL_W-1:0]     r_digit_sel;
    logic [6:0]           r_seg;
    logic [DIGITS-1:0]    r_an;

    logic                 w_inc;
    logic [4*DIGITS-1:0]  w_count_nxt;
    logic                 w_wrap;
    bcd_digit_t           w_digit;
    logic                 w_blank;
    logic [6:0]           w_seg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
        end else begin
            r_sync1   <= pulse_in;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db_level;
            // Any sample agreeing with the current level restarts the stability window
            if (r_sync2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_level <= r_sync2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_inc = r_db_level & ~r_db_prev;

    // Ripple carry across digits; a carry out of the top digit is a full wrap
    always_comb begin
        logic carry;
        w_count_nxt = r_count;
        carry       = w_inc;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_count_nxt[4*i +: 4] = 4'd0;
                end else begin
                    w_count_nxt[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        w_wrap = carry;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_latch    <= '0;
        end else begin
            if (clear) begin
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                r_count <= w_count_nxt;
                if (w_wrap) r_overflow <= 1'b1;
            end
            if (clear)      r_latch <= '0;
            else if (!hold) r_latch <= r_count;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= '0;
        end else if (r_scan_cnt == SC_LAST) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= (r_digit_sel == SEL_LAST) ? '0 : r_digit_sel + 1'b1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] w_lz;

    always_comb begin
        logic zero_above;
        w_lz       = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (r_latch[4*i +: 4] == 4'd0);
            w_lz[i]    = zero_above;
        end
    end
`endif

    always_comb begin
        w_digit = '0;
        w_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (SEL_W'(i) == r_digit_sel) begin
                w_digit = r_latch[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                w_blank = w_lz[i];
`else
                w_blank = 1'b0;
`endif
            end
        end
    end

    seg7_decoder u_dec (
        .i_digit (w_digit),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= '1;
        end else begin
            r_seg <= w_seg;
            r_an  <= ~(DIGITS'(1) << r_digit_sel);
        end
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign count_bcd = r_count;
    assign overflow  = r_overflow;

endmodule
